// File: rtl/x_branch_ctrl.sv
// ---------------------------------------------------------------------------
// x_branch_ctrl
//
// Execute-stage control and branch-resolution unit for an RV32I pipeline.
// Decodes the X-stage instruction into ALU operand selects and the branch
// compare mode, compares the forwarded operands, resolves conditional
// branches and jumps against the fetch-stage prediction, and owns a table of
// 2-bit saturating counters (BHT) that supplies that prediction.
//
// Ports
//   clk, rst         clock; synchronous active-high reset
//   f_pc             fetch PC used for the BHT lookup
//   f_pred_taken     prediction for f_pc (combinational, read-before-write)
//   x_valid/x_stall  X-stage holds a real instruction / X-stage frozen
//   x_opcode/funct3  X-stage instruction fields
//   x_pc             X-stage PC (indexes the BHT on update)
//   x_rs1/x_rs2      forwarded operand values
//   x_pred_taken     prediction carried down from fetch
//   x_asel           ALU A select: 0 rs1, 1 PC, 2 zero
//   x_bsel           ALU B select: 0 rs2, 1 immediate
//   x_brun           unsigned branch compare (bltu/bgeu)
//   x_pcsel          0 sequential, 1 ALU target, 2 x_pc+4 correction
//   x_flush          kill F/D this cycle
//   br_count         resolved conditional branches (saturating)
//   mispred_count    mispredicted conditional branches + jumps (saturating)
// ---------------------------------------------------------------------------
module x_branch_ctrl #(
  parameter int XLEN        = 32,
  parameter int BHT_ENTRIES = 16,
  parameter int CNT_W       = 32,
  localparam int IDX        = $clog2(BHT_ENTRIES)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [XLEN-1:0]  f_pc,
  output logic             f_pred_taken,
  input  logic             x_valid,
  input  logic             x_stall,
  input  logic [6:0]       x_opcode,
  input  logic [2:0]       x_funct3,
  input  logic [XLEN-1:0]  x_pc,
  input  logic [XLEN-1:0]  x_rs1,
  input  logic [XLEN-1:0]  x_rs2,
  input  logic             x_pred_taken,
  output logic [1:0]       x_asel,
  output logic             x_bsel,
  output logic             x_brun,
  output logic [1:0]       x_pcsel,
  output logic             x_flush,
  output logic [CNT_W-1:0] br_count,
  output logic [CNT_W-1:0] mispred_count
);

  // RV32I major opcodes
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;

  typedef enum logic [1:0] {
    ASEL_RS1  = 2'd0,
    ASEL_PC   = 2'd1,
    ASEL_ZERO = 2'd2
  } asel_e;

  typedef enum logic [1:0] {
    PCSEL_SEQ  = 2'd0,
    PCSEL_ALU  = 2'd1,
    PCSEL_CORR = 2'd2
  } pcsel_e;

  localparam logic [1:0] CTR_RESET = 2'b01;  // weakly not-taken

  // -------------------------------------------------------------------------
  // State
  // -------------------------------------------------------------------------
  logic [1:0]       bht [BHT_ENTRIES];
  logic             kill_q;

  // -------------------------------------------------------------------------
  // Decode
  // -------------------------------------------------------------------------
  asel_e  asel;
  logic   bsel;
  logic   is_branch;
  logic   is_jump;
  logic   cond_f3;     // funct3 names a real conditional branch

  // NOTE: every always_comb output gets a default first, so no path can
  // leave a signal unassigned and infer a latch.
  always_comb begin
    asel = ASEL_RS1;
    bsel = 1'b1;
    unique case (x_opcode)
      OP_R:                          begin asel = ASEL_RS1;  bsel = 1'b0; end
      OP_I, OP_LOAD, OP_STORE,
      OP_JALR:                       begin asel = ASEL_RS1;  bsel = 1'b1; end
      OP_BRANCH, OP_JAL, OP_AUIPC:   begin asel = ASEL_PC;   bsel = 1'b1; end
      OP_LUI:                        begin asel = ASEL_ZERO; bsel = 1'b1; end
      default:                       begin asel = ASEL_RS1;  bsel = 1'b1; end
    endcase
  end

  assign is_branch = (x_opcode == OP_BRANCH);
  assign is_jump   = (x_opcode == OP_JAL) || (x_opcode == OP_JALR);
  assign cond_f3   = (x_funct3[2:1] != 2'b01);

  assign x_asel = asel;
  assign x_bsel = bsel;
  assign x_brun = is_branch && (x_funct3[2:1] == 2'b11);

  // -------------------------------------------------------------------------
  // Compare and resolve
  // -------------------------------------------------------------------------
  logic eq;
  logic lt;
  logic taken;

  assign eq = (x_rs1 == x_rs2);
  assign lt = x_brun ? (x_rs1 < x_rs2) : ($signed(x_rs1) < $signed(x_rs2));

  always_comb begin
    taken = 1'b0;
    unique case (x_funct3)
      3'b000:  taken = eq;
      3'b001:  taken = ~eq;
      3'b100,
      3'b110:  taken = lt;
      3'b101,
      3'b111:  taken = ~lt;
      default: taken = 1'b0;  // 010/011: treated as not-taken
    endcase
  end

  // An instruction arriving in X right after a redirect is wrong-path.
  logic v;
  logic fire;

  assign v    = x_valid & ~kill_q;
  assign fire = v & ~x_stall;

  pcsel_e pcsel;

  always_comb begin
    pcsel = PCSEL_SEQ;
    if (fire) begin
      if (is_jump) begin
        pcsel = PCSEL_ALU;
      end else if (is_branch) begin
        if (cond_f3 && taken && !x_pred_taken)
          pcsel = PCSEL_ALU;
        else if (!taken && x_pred_taken)
          pcsel = PCSEL_CORR;
      end
    end
  end

  assign x_pcsel = pcsel;
  assign x_flush = (pcsel != PCSEL_SEQ);

  // -------------------------------------------------------------------------
  // Update qualifiers
  // -------------------------------------------------------------------------
  logic           bht_upd;
  logic           mispred;
  logic [IDX-1:0] upd_idx;
  logic [IDX-1:0] look_idx;

  assign bht_upd  = fire && is_branch && cond_f3;
  assign mispred  = (bht_upd && (pcsel != PCSEL_SEQ)) || (fire && is_jump);
  assign upd_idx  = x_pc[IDX+1:2];
  assign look_idx = f_pc[IDX+1:2];

  // Reads the registered array, so a same-cycle update to this index shows
  // up only after the edge.
  assign f_pred_taken = bht[look_idx][1];

  // -------------------------------------------------------------------------
  // Sequential state
  // -------------------------------------------------------------------------
  // NOTE: state uses non-blocking assignments so every register samples the
  // pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the BHT is a register array, not a RAM macro, so it can be
      // reset in one cycle; prediction must start weakly not-taken.
      for (int i = 0; i < BHT_ENTRIES; i++) bht[i] <= CTR_RESET;
      kill_q        <= 1'b0;
      br_count      <= '0;
      mispred_count <= '0;
    end else if (!x_stall) begin
      kill_q <= (pcsel != PCSEL_SEQ);

      if (bht_upd) begin
        if (taken && (bht[upd_idx] != 2'b11))
          bht[upd_idx] <= bht[upd_idx] + 2'd1;
        else if (!taken && (bht[upd_idx] != 2'b00))
          bht[upd_idx] <= bht[upd_idx] - 2'd1;

        if (br_count != '1)
          br_count <= br_count + CNT_W'(1);
      end

      if (mispred && (mispred_count != '1))
        mispred_count <= mispred_count + CNT_W'(1);
    end
  end

  // PC bits outside the BHT index do not affect this block.
  logic unused_pc_bits;
  assign unused_pc_bits = ^{f_pc[XLEN-1:IDX+2], f_pc[1:0],
                            x_pc[XLEN-1:IDX+2], x_pc[1:0]};

endmodule

// File: tb/tb_x_branch_ctrl.sv
module tb_x_branch_ctrl;

  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BR  = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;
  localparam logic [6:0] OP_JR  = 7'b1100111;
  localparam logic [6:0] OP_AUI = 7'b0010111;
  localparam logic [6:0] OP_LUI = 7'b0110111;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] f_pc;
  logic        f_pred_taken;
  logic        x_valid, x_stall;
  logic [6:0]  x_opcode;
  logic [2:0]  x_funct3;
  logic [31:0] x_pc, x_rs1, x_rs2;
  logic        x_pred_taken;
  logic [1:0]  x_asel;
  logic        x_bsel, x_brun;
  logic [1:0]  x_pcsel;
  logic        x_flush;
  logic [31:0] br_count, mispred_count;

  x_branch_ctrl #(.XLEN(32), .BHT_ENTRIES(16), .CNT_W(32)) dut (
    .clk(clk), .rst(rst), .f_pc(f_pc), .f_pred_taken(f_pred_taken),
    .x_valid(x_valid), .x_stall(x_stall), .x_opcode(x_opcode),
    .x_funct3(x_funct3), .x_pc(x_pc), .x_rs1(x_rs1), .x_rs2(x_rs2),
    .x_pred_taken(x_pred_taken), .x_asel(x_asel), .x_bsel(x_bsel),
    .x_brun(x_brun), .x_pcsel(x_pcsel), .x_flush(x_flush),
    .br_count(br_count), .mispred_count(mispred_count)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h want=0x%0h", tag, got, exp);
    end
  endtask

  // Reference model state
  int m_bht [16];
  bit m_kill;
  int m_br, m_mis;

  typedef struct {
    string      tag;
    logic [1:0] asel;
    logic       bsel;
    logic       brun;
    logic [1:0] pcsel;
    logic       flush;
    logic       fpred;
  } exp_t;

  exp_t sb[$];

  task automatic model_reset();
    for (int i = 0; i < 16; i++) m_bht[i] = 1;
    m_kill = 1'b0;
    m_br   = 0;
    m_mis  = 0;
  endtask

  // Drive one X-stage cycle, queue the expected combinational outputs,
  // compare them before the edge, then advance the model across the edge.
  task automatic step(input string tag, input bit valid, input bit stall,
                      input logic [6:0] op, input logic [2:0] f3,
                      input logic [31:0] pc, input logic [31:0] a,
                      input logic [31:0] b, input bit pred,
                      input logic [31:0] fpc);
    exp_t e, o;
    bit   tk, live, real_br, cond;
    int   idx;
    @(negedge clk);
    x_valid = valid; x_stall = stall; x_opcode = op; x_funct3 = f3;
    x_pc = pc; x_rs1 = a; x_rs2 = b; x_pred_taken = pred; f_pc = fpc;

    e.tag = tag;
    case (op)
      OP_R:                 begin e.asel = 2'd0; e.bsel = 1'b0; end
      OP_BR, OP_JAL, OP_AUI: begin e.asel = 2'd1; e.bsel = 1'b1; end
      OP_LUI:               begin e.asel = 2'd2; e.bsel = 1'b1; end
      default:              begin e.asel = 2'd0; e.bsel = 1'b1; end
    endcase
    e.brun = (op == OP_BR) && (f3 == 3'b110 || f3 == 3'b111);
    case (f3)
      3'b000: tk = (a == b);
      3'b001: tk = (a != b);
      3'b100: tk = ($signed(a) < $signed(b));
      3'b101: tk = !($signed(a) < $signed(b));
      3'b110: tk = (a < b);
      3'b111: tk = !(a < b);
      default: tk = 1'b0;
    endcase
    cond    = !(f3 == 3'b010 || f3 == 3'b011);
    live    = valid && !m_kill && !stall;
    real_br = live && (op == OP_BR) && cond;
    e.pcsel = 2'd0;
    if (live && (op == OP_JAL || op == OP_JR)) e.pcsel = 2'd1;
    else if (live && op == OP_BR) begin
      if (cond && tk && !pred)   e.pcsel = 2'd1;
      else if (!tk && pred)      e.pcsel = 2'd2;
    end
    e.flush = (e.pcsel != 2'd0);
    e.fpred = (m_bht[fpc[5:2]] >= 2);
    sb.push_back(e);

    #1;
    o = sb.pop_front();
    check({o.tag, ".asel"},  {30'd0, x_asel},  {30'd0, o.asel});
    check({o.tag, ".bsel"},  {31'd0, x_bsel},  {31'd0, o.bsel});
    check({o.tag, ".brun"},  {31'd0, x_brun},  {31'd0, o.brun});
    check({o.tag, ".pcsel"}, {30'd0, x_pcsel}, {30'd0, o.pcsel});
    check({o.tag, ".flush"}, {31'd0, x_flush}, {31'd0, o.flush});
    check({o.tag, ".fpred"}, {31'd0, f_pred_taken}, {31'd0, o.fpred});

    @(posedge clk);
    if (rst) model_reset();
    else if (!stall) begin
      if (real_br) begin
        idx = pc[5:2];
        if (tk && m_bht[idx] < 3) m_bht[idx]++;
        if (!tk && m_bht[idx] > 0) m_bht[idx]--;
        m_br++;
        if (e.pcsel != 0) m_mis++;
      end
      if (live && (op == OP_JAL || op == OP_JR)) m_mis++;
      m_kill = (e.pcsel != 0);
    end
    #1;
    check({tag, ".br_count"}, br_count, m_br);
    check({tag, ".mis_count"}, mispred_count, m_mis);
  endtask

  task automatic bubble(input string tag, input logic [31:0] fpc);
    step(tag, 1'b0, 1'b0, OP_I, 3'b000, 32'h0, 32'h0, 32'h0, 1'b0, fpc);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; x_valid = 1'b0; x_stall = 1'b0;
    @(posedge clk);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout want=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b0; x_valid = 1'b0; x_stall = 1'b0; x_opcode = OP_I;
    x_funct3 = 3'b000; x_pc = '0; x_rs1 = '0; x_rs2 = '0;
    x_pred_taken = 1'b0; f_pc = '0;
    model_reset();
    do_reset();

    // Reset state: every entry weakly not-taken, no redirect.
    #1;
    check("rst.pcsel", {30'd0, x_pcsel}, 32'd0);
    check("rst.flush", {31'd0, x_flush}, 32'd0);
    check("rst.br", br_count, 32'd0);
    check("rst.mis", mispred_count, 32'd0);
    for (int i = 0; i < 16; i++) bubble("sweep", 32'(i * 4));

    // Taken beq mispredicted; next instruction killed; BHT[0] -> 10.
    step("beq", 1, 0, OP_BR, 3'b000, 32'h40, 32'd5, 32'd5, 1'b0, 32'h0);
    step("bne_killed", 1, 0, OP_BR, 3'b001, 32'h44, 32'd1, 32'd2, 1'b0, 32'h0);
    bubble("pred40", 32'h40);
    check("beq.pred40_now", {31'd0, f_pred_taken}, 32'd1);
    check("beq.br_abs", br_count, 32'd1);
    check("beq.mis_abs", mispred_count, 32'd1);

    // Signed vs unsigned compare on the same operands.
    step("bltu_nt", 1, 0, OP_BR, 3'b110, 32'h48, 32'hFFFF_FFFF, 32'd1, 1'b0, 32'h48);
    step("blt_t", 1, 0, OP_BR, 3'b100, 32'h4C, 32'hFFFF_FFFF, 32'd1, 1'b0, 32'h4C);
    bubble("after_blt", 32'h4C);
    step("bltu_pred", 1, 0, OP_BR, 3'b110, 32'h48, 32'hFFFF_FFFF, 32'd1, 1'b1, 32'h48);
    bubble("after_bltu", 32'h48);
    step("bgeu_t", 1, 0, OP_BR, 3'b111, 32'h48, 32'hFFFF_FFFF, 32'd1, 1'b1, 32'h48);

    // Saturation with interleaved stalls at index 4.
    for (int k = 0; k < 4; k++) begin
      step("sat_stall", 1, 1, OP_BR, 3'b000, 32'h50, 32'd7, 32'd7, 1'b1, 32'h50);
      step("sat_take", 1, 0, OP_BR, 3'b000, 32'h50, 32'd7, 32'd7, 1'b1, 32'h50);
    end
    step("sat_nt", 1, 0, OP_BR, 3'b000, 32'h50, 32'd7, 32'd8, 1'b1, 32'h50);
    bubble("sat_after", 32'h50);
    check("sat.pred_abs", {31'd0, f_pred_taken}, 32'd1);

    // Select decode, jumps, reserved branch funct3.
    step("lui", 1, 0, OP_LUI, 3'b000, 32'h58, 32'd0, 32'd0, 1'b0, 32'h58);
    step("rtype", 1, 0, OP_R, 3'b000, 32'h5C, 32'd0, 32'd0, 1'b0, 32'h5C);
    step("auipc", 1, 0, OP_AUI, 3'b000, 32'h5C, 32'd0, 32'd0, 1'b0, 32'h5C);
    step("jalr", 1, 0, OP_JR, 3'b000, 32'h60, 32'd0, 32'd0, 1'b0, 32'h60);
    bubble("after_jalr", 32'h60);
    check("jalr.bht_abs", {31'd0, f_pred_taken}, 32'd0);
    step("jal", 1, 0, OP_JAL, 3'b000, 32'h64, 32'd0, 32'd0, 1'b1, 32'h64);
    bubble("after_jal", 32'h64);
    step("br010", 1, 0, OP_BR, 3'b010, 32'h68, 32'd3, 32'd3, 1'b1, 32'h68);
    bubble("after_br010", 32'h68);
    check("br010.pred_abs", {31'd0, f_pred_taken}, 32'd0);

    // Read-before-write on the same index.
    step("rbw", 1, 0, OP_BR, 3'b000, 32'h70, 32'd1, 32'd1, 1'b1, 32'h70);
    bubble("rbw_next", 32'h70);

    // Reset during a redirect wins over the update.
    rst = 1'b1;
    step("rst_redirect", 1, 0, OP_JAL, 3'b000, 32'h80, 32'd0, 32'd0, 1'b0, 32'h40);
    rst = 1'b0;
    check("rst2.br_abs", br_count, 32'd0);
    check("rst2.mis_abs", mispred_count, 32'd0);
    step("post_rst_jal", 1, 0, OP_JAL, 3'b000, 32'h84, 32'd0, 32'd0, 1'b0, 32'h50);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
